// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Multi-cycle subtractor: computes diff = a - b - bin over WIDTH bits,
// DIGIT bits per clock, using a ripple chain of DIGIT full-subtractor slices
// and a borrow register that carries between steps. Trades latency
// (WIDTH/DIGIT cycles) for a small datapath.
//
// WIDTH must be a multiple of DIGIT, WIDTH >= 2, 1 <= DIGIT <= WIDTH.
//
// Ports:
//   clk_i    rising-edge clock
//   rst_i    asynchronous active-high reset
//   start_i  request a new operation (sampled only while idle)
//   a_i      minuend, captured on the accepting edge
//   b_i      subtrahend, captured on the accepting edge
//   bin_i    borrow-in for chaining, captured on the accepting edge
//   busy_o   operation in progress
//   done_o   one-cycle pulse when diff_o/bo_o/zero_o are updated
//   diff_o   (a - b - bin) mod 2^WIDTH, held until the next completion
//   bo_o     final borrow-out, 1 iff a < b + bin (unsigned)
//   zero_o   1 iff diff_o == 0
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             bo_o,
    output logic             zero_o
);

    localparam int NSTEP = WIDTH / DIGIT;
    localparam int CW    = $clog2(NSTEP + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] aSh_q;
    logic [WIDTH-1:0] bSh_q;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] part_q;
    logic [WIDTH-1:0] diff_q;
    logic             bo_q;
    logic             zero_q;
    logic             busy_q;
    logic             done_q;

    logic [DIGIT-1:0] sliceDiff;
    logic             bwRun;
    logic             borrow_d;
    logic [WIDTH-1:0] part_d;
    logic [CW-1:0]    cnt_d;

    // One step of the datapath: the slice chain works on the low DIGIT bits
    // of the operand shift registers, rippling the borrow from the borrow
    // register upward. The new difference bits enter at the MSB end of the
    // partial result so that after NSTEP steps the LSB digit has travelled
    // all the way down to bit 0.
    always_comb begin
        sliceDiff = '0;
        bwRun     = borrow_q;
        for (int i = 0; i < DIGIT; i++) begin
            sliceDiff[i] = aSh_q[i] ^ bSh_q[i] ^ bwRun;
            bwRun        = (~aSh_q[i] & bSh_q[i]) | (~(aSh_q[i] ^ bSh_q[i]) & bwRun);
        end
        borrow_d = bwRun;
        part_d   = (part_q >> DIGIT) | (WIDTH'(sliceDiff) << (WIDTH - DIGIT));
        cnt_d    = cnt_q + CW'(1);
    end

    // Control FSM and all registers. The visible results (diff/bo/zero) are
    // written only on the completing step, so they keep the previous result
    // for the whole of a run.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            aSh_q    <= '0;
            bSh_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            part_q   <= '0;
            diff_q   <= '0;
            bo_q     <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        aSh_q    <= a_i;
                        bSh_q    <= b_i;
                        borrow_q <= bin_i;
                        cnt_q    <= '0;
                        part_q   <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    aSh_q    <= aSh_q >> DIGIT;
                    bSh_q    <= bSh_q >> DIGIT;
                    borrow_q <= borrow_d;
                    part_q   <= part_d;
                    cnt_q    <= cnt_d;
                    // Last step: publish the result taken straight from the
                    // next-state values so no extra cycle is spent.
                    if (cnt_d == CW'(NSTEP)) begin
                        diff_q  <= part_d;
                        bo_q    <= borrow_d;
                        zero_q  <= (part_d == '0);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign diff_o = diff_q;
    assign bo_o   = bo_q;
    assign zero_o = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed and random vectors for serial_subtractor at WIDTH=8 with
// DIGIT=1, 4 and 8 (one instance each). Expected values come from a 9-bit
// unsigned subtraction model inside the bench.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start1, start4, start8;
    logic [7:0] aIn, bIn;
    logic       binIn;

    logic       busy1, done1, bo1, zero1;
    logic       busy4, done4, bo4, zero4;
    logic       busy8, done8, bo8, zero8;
    logic [7:0] diff1, diff4, diff8;

    int         vecCount  = 0;
    int         missCount = 0;
    int         sel;
    logic [7:0] lastDiff [0:2];

    logic       busyS, doneS, boS, zeroS;
    logic [7:0] diffS;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .a_i(aIn), .b_i(bIn), .bin_i(binIn),
        .busy_o(busy1), .done_o(done1), .diff_o(diff1), .bo_o(bo1), .zero_o(zero1)
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4), .a_i(aIn), .b_i(bIn), .bin_i(binIn),
        .busy_o(busy4), .done_o(done4), .diff_o(diff4), .bo_o(bo4), .zero_o(zero4)
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .a_i(aIn), .b_i(bIn), .bin_i(binIn),
        .busy_o(busy8), .done_o(done8), .diff_o(diff8), .bo_o(bo8), .zero_o(zero8)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Route the outputs of the instance under test to one set of signals so
    // the stimulus task can be shared between all three configurations.
    always_comb begin
        busyS = busy8;
        doneS = done8;
        diffS = diff8;
        boS   = bo8;
        zeroS = zero8;
        case (sel)
            0: begin
                busyS = busy1; doneS = done1; diffS = diff1; boS = bo1; zeroS = zero1;
            end
            1: begin
                busyS = busy4; doneS = done4; diffS = diff4; boS = bo4; zeroS = zero4;
            end
            default: ;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic driveStart(input logic v);
        case (sel)
            0:       start1 = v;
            1:       start4 = v;
            default: start8 = v;
        endcase
    endtask

    // One full operation on the selected instance: start pulse, then check
    // every edge up to completion at exactly lat edges after acceptance.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic bin, input int lat);
        logic [8:0] full;
        logic [7:0] prior;
        full  = {1'b0, a} - {1'b0, b} - {8'd0, bin};
        prior = lastDiff[sel];
        @(negedge clk);
        aIn   = a;
        bIn   = b;
        binIn = bin;
        driveStart(1'b1);
        @(posedge clk);
        #1;
        driveStart(1'b0);
        checkOutput("accept_busy", {31'd0, busyS}, 32'd1);
        checkOutput("accept_done", {31'd0, doneS}, 32'd0);
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk);
            #1;
            if (k < lat) begin
                checkOutput("run_busy", {31'd0, busyS}, 32'd1);
                checkOutput("run_done", {31'd0, doneS}, 32'd0);
                checkOutput("run_diff_hold", {24'd0, diffS}, {24'd0, prior});
            end else begin
                checkOutput("done_pulse", {31'd0, doneS}, 32'd1);
                checkOutput("done_busy", {31'd0, busyS}, 32'd0);
                checkOutput("diff", {24'd0, diffS}, {24'd0, full[7:0]});
                checkOutput("bo", {31'd0, boS}, {31'd0, full[8]});
                checkOutput("zero", {31'd0, zeroS}, {31'd0, (full[7:0] == 8'd0)});
            end
        end
        lastDiff[sel] = full[7:0];
    endtask

    initial begin
        rst      = 1'b1;
        start1   = 1'b0;
        start4   = 1'b0;
        start8   = 1'b0;
        aIn      = '0;
        bIn      = '0;
        binIn    = 1'b0;
        sel      = 0;
        lastDiff[0] = 8'd0;
        lastDiff[1] = 8'd0;
        lastDiff[2] = 8'd0;

        // Reset state.
        #12;
        checkOutput("rst_busy", {31'd0, busy1}, 32'd0);
        checkOutput("rst_done", {31'd0, done1}, 32'd0);
        checkOutput("rst_diff", {24'd0, diff1}, 32'd0);
        checkOutput("rst_bo", {31'd0, bo1}, 32'd0);
        checkOutput("rst_zero", {31'd0, zero1}, 32'd0);
        checkOutput("rst_diff8", {24'd0, diff8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // DIGIT=1 directed vectors.
        sel = 0;
        applyStimulus(8'h5A, 8'h3C, 1'b0, 8);
        @(posedge clk);
        #1;
        checkOutput("done_width", {31'd0, done1}, 32'd0);
        checkOutput("idle_diff_hold", {24'd0, diff1}, 32'h1E);
        applyStimulus(8'h00, 8'h01, 1'b0, 8);
        applyStimulus(8'h10, 8'h0F, 1'b1, 8);
        applyStimulus(8'h00, 8'h00, 1'b1, 8);
        applyStimulus(8'h10, 8'h0F, 1'b1, 8);

        // START held high with operands changed mid-run: first run uses the
        // captured operands, the second one is accepted right after DONE.
        @(negedge clk);
        aIn    = 8'h11;
        bIn    = 8'h22;
        binIn  = 1'b0;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("hold_accept_busy", {31'd0, busy1}, 32'd1);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) begin
                aIn = 8'h99;
                bIn = 8'h01;
            end
            if (k < 8) begin
                checkOutput("hold_run_busy", {31'd0, busy1}, 32'd1);
                checkOutput("hold_run_done", {31'd0, done1}, 32'd0);
            end else begin
                checkOutput("hold_done", {31'd0, done1}, 32'd1);
                checkOutput("hold_diff", {24'd0, diff1}, 32'hEF);
                checkOutput("hold_bo", {31'd0, bo1}, 32'd1);
            end
        end
        @(posedge clk);
        #1;
        start1 = 1'b0;
        checkOutput("b2b_accept_busy", {31'd0, busy1}, 32'd1);
        checkOutput("b2b_accept_done", {31'd0, done1}, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k < 8) begin
                checkOutput("b2b_run_diff_hold", {24'd0, diff1}, 32'hEF);
                checkOutput("b2b_run_done", {31'd0, done1}, 32'd0);
            end else begin
                checkOutput("b2b_done", {31'd0, done1}, 32'd1);
                checkOutput("b2b_diff", {24'd0, diff1}, 32'h98);
                checkOutput("b2b_bo", {31'd0, bo1}, 32'd0);
            end
        end
        lastDiff[0] = 8'h98;

        // Reset in the middle of a run aborts it without DONE.
        @(negedge clk);
        aIn    = 8'h12;
        bIn    = 8'h01;
        binIn  = 1'b0;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", {31'd0, busy1}, 32'd0);
        checkOutput("abort_diff", {24'd0, diff1}, 32'd0);
        checkOutput("abort_done", {31'd0, done1}, 32'd0);
        checkOutput("abort_bo", {31'd0, bo1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        lastDiff[0] = 8'd0;
        lastDiff[1] = 8'd0;
        lastDiff[2] = 8'd0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            checkOutput("abort_no_done", {31'd0, done1}, 32'd0);
        end
        applyStimulus(8'hFF, 8'h80, 1'b0, 8);

        // DIGIT=4 and DIGIT=8 sweeps, edge cases first.
        for (int s = 1; s <= 2; s++) begin
            sel = s;
            applyStimulus(8'h00, 8'h00, 1'b1, (s == 1) ? 2 : 1);
            applyStimulus(8'h10, 8'h0F, 1'b1, (s == 1) ? 2 : 1);
            applyStimulus(8'h5A, 8'h3C, 1'b0, (s == 1) ? 2 : 1);
            for (int n = 0; n < 256; n++) begin
                applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                              1'($urandom_range(0, 1)), (s == 1) ? 2 : 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
